// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered read data and count-decoded status flags.
// Define SYNC_FIFO_ERR_EN to add sticky overflow/underflow error outputs.
module sync_fifo #(
    parameter int DATA_WIDTH   = 32,
    parameter int DEPTH        = 16,
    parameter int AFULL_LEVEL  = DEPTH - 2,
    parameter int AEMPTY_LEVEL = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  wen,
    output logic                  full,
    output logic                  almost_full,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  rvalid,
    input  logic                  ren,
    output logic                  empty,
    output logic                  almost_empty
`ifdef SYNC_FIFO_ERR_EN
    ,
    output logic                  overflow,
    output logic                  underflow
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  rvalid_q, rvalid_d;
    logic                  wr_accept, rd_accept;

    // Flags come straight from the registered count, so they never glitch.
    assign full         = (count_q == CNT_W'(DEPTH));
    assign empty        = (count_q == '0);
    assign almost_full  = (count_q >= CNT_W'(AFULL_LEVEL));
    assign almost_empty = (count_q <= CNT_W'(AEMPTY_LEVEL));
    assign rdata        = rdata_q;
    assign rvalid       = rvalid_q;

    assign wr_accept = wen && !full;
    assign rd_accept = ren && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        rdata_d  = rdata_q;
        rvalid_d = rd_accept;
        if (wr_accept) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (rd_accept) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
            rdata_d  = mem_q[rd_ptr_q];
        end
        case ({wr_accept, rd_accept})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Storage is intentionally left out of reset.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
        end
    end

`ifdef SYNC_FIFO_ERR_EN
    logic overflow_q, overflow_d;
    logic underflow_q, underflow_d;

    always_comb begin
        overflow_d  = overflow_q  || (wen && full);
        underflow_d = underflow_q || (ren && empty);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign overflow  = overflow_q;
    assign underflow = underflow_q;
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// Scoreboard bench for sync_fifo at DEPTH=8; checks data order, rvalid and all flags every cycle.
module tb_sync_fifo;

    localparam int DW = 32;
    localparam int DEPTH = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [DW-1:0] wdata = '0;
    logic          wen = 1'b0;
    logic          ren = 1'b0;
    logic          full, almost_full, empty, almost_empty, rvalid;
    logic [DW-1:0] rdata;
`ifdef SYNC_FIFO_ERR_EN
    logic          overflow, underflow;
    logic          ovf_m = 1'b0;
    logic          unf_m = 1'b0;
`endif

    int total = 0;
    int bad = 0;
    logic [DW-1:0] model[$];
    logic [DW-1:0] last_rd = '0;

    always #5 clk = ~clk;

    sync_fifo #(
        .DATA_WIDTH  (DW),
        .DEPTH       (DEPTH),
        .AFULL_LEVEL (6),
        .AEMPTY_LEVEL(2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .wdata       (wdata),
        .wen         (wen),
        .full        (full),
        .almost_full (almost_full),
        .rdata       (rdata),
        .rvalid      (rvalid),
        .ren         (ren),
        .empty       (empty),
        .almost_empty(almost_empty)
`ifdef SYNC_FIFO_ERR_EN
        ,
        .overflow    (overflow),
        .underflow   (underflow)
`endif
    );

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic chk_flags();
        int sz;
        sz = model.size();
        chk("empty", empty, sz == 0);
        chk("full", full, sz == DEPTH);
        chk("almost_empty", almost_empty, sz <= 2);
        chk("almost_full", almost_full, sz >= 6);
`ifdef SYNC_FIFO_ERR_EN
        chk("overflow", overflow, ovf_m);
        chk("underflow", underflow, unf_m);
`endif
    endtask

    // One clock of stimulus; expected read data is taken from the model queue.
    task automatic step(input logic w, input logic [DW-1:0] d, input logic r);
        int sz;
        logic wa, ra;
        logic [DW-1:0] exp_rd;
        wen = w;
        wdata = d;
        ren = r;
        sz = model.size();
        wa = w && (sz < DEPTH);
        ra = r && (sz > 0);
`ifdef SYNC_FIFO_ERR_EN
        ovf_m = ovf_m || (w && sz == DEPTH);
        unf_m = unf_m || (r && sz == 0);
`endif
        exp_rd = last_rd;
        @(posedge clk);
        #1;
        if (ra) exp_rd = model.pop_front();
        if (wa) model.push_back(d);
        chk("rvalid", rvalid, ra);
        if (ra) chk("rdata", rdata, exp_rd);
        else chk("rdata_hold", rdata, last_rd);
        last_rd = exp_rd;
        chk_flags();
        wen = 1'b0;
        ren = 1'b0;
    endtask

    task automatic chk_reset_outputs();
        chk("rst_rvalid", rvalid, 1'b0);
        chk("rst_rdata", rdata, '0);
        chk("rst_empty", empty, 1'b1);
        chk("rst_aempty", almost_empty, 1'b1);
        chk("rst_full", full, 1'b0);
        chk("rst_afull", almost_full, 1'b0);
`ifdef SYNC_FIFO_ERR_EN
        chk("rst_overflow", overflow, 1'b0);
        chk("rst_underflow", underflow, 1'b0);
`endif
    endtask

    initial begin
        #2;
        chk_reset_outputs();
        @(negedge clk);
        rst_n = 1'b1;

        // Fill then drain
        for (int i = 1; i <= 8; i++) step(1'b1, DW'(i), 1'b0);
        // Overflow attempt while full
        step(1'b1, 32'hDEAD, 1'b0);
        step(1'b0, '0, 1'b0);
        // Full with simultaneous read and write: read wins, write dropped
        step(1'b1, 32'hBEEF, 1'b1);
        chk("full_rw_not_full", full, 1'b0);
        step(1'b1, 32'h9, 1'b0);
        for (int i = 0; i < 8; i++) step(1'b0, '0, 1'b1);
        chk("drain_empty", empty, 1'b1);

        // Underflow: read and write together on empty
        step(1'b1, 32'hA5, 1'b1);
        chk("unf_rvalid", rvalid, 1'b0);
        step(1'b0, '0, 1'b1);
        chk("unf_readback", rdata, 32'hA5);

        // Wrap-around with count held at 3
        for (int i = 0; i < 3; i++) step(1'b1, 32'h100 + DW'(i), 1'b0);
        for (int i = 0; i < 20; i++) step(1'b1, 32'h200 + DW'(i), 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1);

        // Asynchronous reset at count 5, right after a read
        for (int i = 0; i < 6; i++) step(1'b1, $urandom, 1'b0);
        step(1'b0, '0, 1'b1);
        chk("pre_rst_rvalid", rvalid, 1'b1);
        rst_n = 1'b0;
        #2;
        model.delete();
        last_rd = '0;
`ifdef SYNC_FIFO_ERR_EN
        ovf_m = 1'b0;
        unf_m = 1'b0;
`endif
        chk_reset_outputs();
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b0, '0, 1'b1);
        chk("post_rst_rvalid", rvalid, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, $urandom, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sync_fifo.md
# sync_fifo

- Single-clock, parameterised FIFO that implements the storage end of the team's FIFO handshake.
- Accepts writes (`wdata`/`wen`) and serves reads (`ren` → `rdata`/`rvalid`).
- Drives `full`, `almost_full`, `empty` and `almost_empty` status flags back to the producer/consumer logic.
- Used as the default buffering element between pipeline stages in the datapath.

## Interface
Parameters:
- `DATA_WIDTH`, 32, width of `wdata`/`rdata`
- `DEPTH`, 16, number of entries; power of two, ≥ 2
- `AFULL_LEVEL`, `DEPTH-2`, `almost_full` asserts when count ≥ this value; range 1..DEPTH
- `AEMPTY_LEVEL`, 2, `almost_empty` asserts when count ≤ this value; range 0..DEPTH-1

Ports:
- `clk`, in, 1, sole clock, rising edge
- `rst_n`, in, 1, asynchronous active-low reset
- `wdata`, in, DATA_WIDTH, write data
- `wen`, in, 1, write request
- `full`, out, 1, count == DEPTH
- `almost_full`, out, 1, count ≥ AFULL_LEVEL
- `rdata`, out, DATA_WIDTH, registered read data
- `rvalid`, out, 1, `rdata` valid this cycle
- `ren`, in, 1, read request
- `empty`, out, 1, count == 0
- `almost_empty`, out, 1, count ≤ AEMPTY_LEVEL
- `overflow`, out, 1, sticky error flag; only present with `SYNC_FIFO_ERR_EN`
- `underflow`, out, 1, sticky error flag; only present with `SYNC_FIFO_ERR_EN`

## Operation
- **Storage and state:** DEPTH × DATA_WIDTH array. Write pointer and read pointer are each `$clog2(DEPTH)` bits and wrap naturally from DEPTH-1 to 0. Occupancy counter is `$clog2(DEPTH+1)` bits.
- **Write acceptance:** a write is accepted on an edge where `wen && !full`. `wdata` is stored at the write pointer and the write pointer increments.
- **Read acceptance:** a read is accepted on an edge where `ren && !empty`. The entry at the read pointer is loaded into `rdata` and the read pointer increments.
- **Count update:** +1 for an accepted write only, −1 for an accepted read only, unchanged when both or neither are accepted.
- **Status flags:** all four flags are decoded combinationally from the registered count, so they are glitch-free relative to `clk`.
- **Rejected requests:** a write while full is dropped and the stored data is unchanged. A read while empty is ignored; `rvalid` stays low and `rdata` holds its last value.
- **Simultaneous read/write:**
  - When full: the read is accepted, the write is dropped, and count goes to DEPTH-1.
  - When empty: the write is accepted, the read is ignored (no fall-through), and count goes to 1.
  - Otherwise: both are accepted and count is unchanged.
- **Ordering:** strict FIFO order across pointer wrap-around.

## Timing
- **Reset:** while `rst_n` is low, all of the following hold regardless of `clk`:
  - pointers = 0, count = 0
  - `rdata` = 0, `rvalid` = 0
  - `empty` = 1, `almost_empty` = 1 (AEMPTY_LEVEL ≥ 0)
  - `full` = 0, `almost_full` = 0
  - `overflow` = 0, `underflow` = 0

  Storage contents are not reset. Asserting reset mid-transfer discards all contents immediately. The first accepted operation is on the first rising edge after `rst_n` is released.
- **Read latency:** 1 cycle. After edge N accepts a read, `rdata` and `rvalid` are valid from edge N until edge N+1. `rvalid` is high for exactly one cycle per accepted read. Back-to-back reads give continuous `rvalid`.
- **Write-to-read:** data written at edge N is readable by a `ren` sampled at edge N+1, and returns on `rdata` after edge N+1.
- **Flag latency:** flags update in the same cycle as the count, i.e. directly after the accepting edge. The producer must sample `full` before driving `wen`; no look-ahead is provided.
- **Throughput:** one write and one read per cycle sustained.

## Configuration
- **`SYNC_FIFO_ERR_EN` defined:**
  - `overflow` and `underflow` ports exist.
  - `overflow` sets on any edge with `wen && full`; `underflow` sets on any edge with `ren && empty`.
  - Both are sticky until `rst_n` is asserted.
  - Dropped and ignored operations behave identically to the undefined case.
- **`SYNC_FIFO_ERR_EN` undefined:** the ports and their logic are absent; misuse is silently dropped or ignored as described above.

## Test plan
All scenarios use DEPTH=8, DATA_WIDTH=32, AFULL_LEVEL=6, AEMPTY_LEVEL=2.
- **Fill then drain:** write 0x1..0x8 on consecutive cycles, then read 8 times.
  - `almost_empty` drops after the 3rd write; `almost_full` rises after the 6th; `full` rises after the 8th.
  - Reads return 0x1..0x8 in order, each with a single-cycle `rvalid` one cycle after `ren`.
  - `empty` = 1 after the last read.
- **Overflow:** with the FIFO full, assert `wen` with 0xDEAD.
  - Count stays 8 and 0xDEAD never appears on `rdata`.
  - With `SYNC_FIFO_ERR_EN`: `overflow` = 1 and stays 1.
- **Underflow:** with the FIFO empty, assert `ren` and `wen` (0xA5) together.
  - `rvalid` = 0, count = 1.
  - The next read returns 0xA5.
  - With `SYNC_FIFO_ERR_EN`: `underflow` = 1.
- **Wrap-around:** 20 cycles of simultaneous write/read with count held at 3.
  - Count never changes and data order is preserved across two pointer wraps.
- **Full + simultaneous read/write:** at count = 8, assert `ren` and `wen` together.
  - Count becomes 7, oldest entry returned, write dropped.
- **Reset mid-operation:** pull `rst_n` low asynchronously at count = 5.
  - All outputs take reset values without waiting for a clock edge.
  - After release, the first read attempt gives `rvalid` = 0.
